// File: rtl/prbs15_pkg.sv
// Shared definitions for the PRBS-15 checker: state encoding, polynomial taps
// and the 8-bit-per-cycle prediction and seeding functions.
package prbs15_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SEED   = 2'd1,
      ST_VERIFY = 2'd2,
      ST_LOCKED = 2'd3
   } state_t;

   localparam int PRBS_W   = 15;
   localparam int TAP_NEAR = 14;
   localparam int TAP_FAR  = 15;

   // hist[14] holds the newest bit b[k-1], so b[k-n] lives at index PRBS_W-n
   localparam int TAP_NEAR_IDX = PRBS_W - TAP_NEAR;
   localparam int TAP_FAR_IDX  = PRBS_W - TAP_FAR;

   localparam logic [PRBS_W-1:0] GEN_SEED = 15'h7FFF;

   typedef struct packed {
      logic [PRBS_W-1:0] hist;
      logic [7:0]        bits;
   } step8_t;

   function automatic step8_t prbs15_next8(input logic [PRBS_W-1:0] hist);
      step8_t r;
      logic   nb;
      r.hist = hist;
      r.bits = '0;
      for (int i = 0; i < 8; i++) begin
         nb        = r.hist[TAP_NEAR_IDX] ^ r.hist[TAP_FAR_IDX];
         r.bits[i] = nb;
         r.hist    = {nb, r.hist[PRBS_W-1:1]};
      end
      return r;
   endfunction

   function automatic logic [PRBS_W-1:0] prbs15_shift8(input logic [PRBS_W-1:0] hist,
                                                       input logic [7:0]        din);
      logic [PRBS_W-1:0] h;
      h = hist;
      for (int i = 0; i < 8; i++) begin
         h = {din[i], h[PRBS_W-1:1]};
      end
      return h;
   endfunction

endpackage

// File: rtl/prbs15_popcount8.sv
// Combinational population count of an 8-bit mismatch vector (0..8).
module prbs15_popcount8 (
   input  logic [7:0] data_in,
   output logic [3:0] count
);

   always_comb begin
      count = '0;
      for (int i = 0; i < 8; i++) begin
         count = count + {3'b000, data_in[i]};
      end
   end

endmodule

// File: rtl/prbs15_checker.sv
// Byte-wide PRBS-15 (x^15+x^14+1) checker: seeds from the stream, verifies,
// locks, and counts bit errors and bytes while locked.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_IDLE   | disabled; counters for seeding/lock/loss cleared
// ST_SEED   | loading two received bytes into the history register
// ST_VERIFY | predicting; LOCK_CNT consecutive clean bytes needed to lock
// ST_LOCKED | predicting and counting; LOSS_CNT errored bytes drop lock
module prbs15_checker
   import prbs15_pkg::*;
#(
   parameter int LOCK_CNT = 4,
   parameter int LOSS_CNT = 4,
   parameter int CNT_W    = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             enable,
   input  logic             valid_in,
   input  logic [7:0]       byte_in,
   input  logic             clear_cnt,
   output logic             locked,
   output logic             err_flag,
   output logic [3:0]       bit_errs,
   output logic [CNT_W-1:0] err_cnt,
   output logic [CNT_W-1:0] byte_cnt
);

   localparam int GOOD_W = (LOCK_CNT > 1) ? $clog2(LOCK_CNT) : 1;
   localparam int BAD_W  = (LOSS_CNT > 1) ? $clog2(LOSS_CNT) : 1;

   state_t            state_q, state_d;
   logic [PRBS_W-1:0] hist_q, hist_d;
   logic              seed_q, seed_d;
   logic [GOOD_W-1:0] good_q, good_d;
   logic [BAD_W-1:0]  bad_q, bad_d;
   logic              locked_q, locked_d;
   logic              err_flag_q, err_flag_d;
   logic [3:0]        bit_errs_q, bit_errs_d;
   logic [CNT_W-1:0]  err_cnt_q, err_cnt_d;
   logic [CNT_W-1:0]  byte_cnt_q, byte_cnt_d;

   logic              accept;
   step8_t            step;
   logic [7:0]        mismatch;
   logic [3:0]        errs;
   logic              clean;
   logic [CNT_W:0]    err_sum;

   prbs15_popcount8 u_popcount (
      .data_in (mismatch),
      .count   (errs)
   );

   always_comb begin
      accept   = enable & valid_in;
      step     = prbs15_next8(hist_q);
      mismatch = byte_in ^ step.bits;
      clean    = (errs == 4'd0);
      err_sum  = {1'b0, err_cnt_q} + (CNT_W+1)'(errs);

      state_d    = state_q;
      hist_d     = hist_q;
      seed_d     = seed_q;
      good_d     = good_q;
      bad_d      = bad_q;
      err_flag_d = 1'b0;
      bit_errs_d = bit_errs_q;
      err_cnt_d  = err_cnt_q;
      byte_cnt_d = byte_cnt_q;

      if (!enable) begin
         state_d = ST_IDLE;
         seed_d  = 1'b0;
         good_d  = '0;
         bad_d   = '0;
      end else begin
         case (state_q)
            ST_IDLE: state_d = ST_SEED;
            ST_SEED: begin
               if (accept) begin
                  hist_d     = prbs15_shift8(hist_q, byte_in);
                  bit_errs_d = 4'd0;
                  if (seed_q) begin
                     seed_d = 1'b0;
                     good_d = '0;
                     // an all-zero history would self-predict zeros forever
                     if (hist_d != '0) state_d = ST_VERIFY;
                  end else begin
                     seed_d = 1'b1;
                  end
               end
            end
            ST_VERIFY: begin
               if (accept) begin
                  hist_d     = step.hist;
                  bit_errs_d = errs;
                  if (!clean) begin
                     state_d = ST_SEED;
                     good_d  = '0;
                  end else if (good_q == GOOD_W'(LOCK_CNT - 1)) begin
                     state_d = ST_LOCKED;
                     good_d  = '0;
                     bad_d   = '0;
                  end else begin
                     good_d = good_q + GOOD_W'(1);
                  end
               end
            end
            ST_LOCKED: begin
               if (accept) begin
                  hist_d     = step.hist;
                  bit_errs_d = errs;
                  err_flag_d = ~clean;
                  if (clean) begin
                     bad_d = '0;
                  end else if (bad_q == BAD_W'(LOSS_CNT - 1)) begin
                     state_d = ST_SEED;
                     bad_d   = '0;
                  end else begin
                     bad_d = bad_q + BAD_W'(1);
                  end
                  err_cnt_d  = err_sum[CNT_W] ? '1 : err_sum[CNT_W-1:0];
                  byte_cnt_d = (byte_cnt_q == '1) ? byte_cnt_q : byte_cnt_q + CNT_W'(1);
               end
            end
            default: state_d = ST_IDLE;
         endcase
      end

      if (clear_cnt) begin
         err_cnt_d  = '0;
         byte_cnt_d = '0;
      end

      locked_d = (state_d == ST_LOCKED);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= ST_IDLE;
         hist_q     <= '0;
         seed_q     <= 1'b0;
         good_q     <= '0;
         bad_q      <= '0;
         locked_q   <= 1'b0;
         err_flag_q <= 1'b0;
         bit_errs_q <= '0;
         err_cnt_q  <= '0;
         byte_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         hist_q     <= hist_d;
         seed_q     <= seed_d;
         good_q     <= good_d;
         bad_q      <= bad_d;
         locked_q   <= locked_d;
         err_flag_q <= err_flag_d;
         bit_errs_q <= bit_errs_d;
         err_cnt_q  <= err_cnt_d;
         byte_cnt_q <= byte_cnt_d;
      end
   end

   assign locked   = locked_q;
   assign err_flag = err_flag_q;
   assign bit_errs = bit_errs_q;
   assign err_cnt  = err_cnt_q;
   assign byte_cnt = byte_cnt_q;

endmodule

// File: tb/tb_prbs15_checker.sv
// Directed bench for prbs15_checker: a 16-bit and a 4-bit counter instance
// share one stimulus stream from a reference PRBS-15 generator.
module tb_prbs15_checker;

   logic        clk = 1'b0;
   logic        rst;
   logic        enable;
   logic        valid_in;
   logic [7:0]  byte_in;
   logic        clear_cnt;

   logic        locked_a, err_flag_a;
   logic [3:0]  bit_errs_a;
   logic [15:0] err_cnt_a, byte_cnt_a;

   logic        locked_b, err_flag_b;
   logic [3:0]  bit_errs_b;
   logic [3:0]  err_cnt_b, byte_cnt_b;

   int          n_err = 0;
   int          n_chk = 0;
   logic [14:0] gen_q;

   always #5 clk = ~clk;

   prbs15_checker #(.LOCK_CNT(4), .LOSS_CNT(4), .CNT_W(16)) dut_a (
      .clk(clk), .rst(rst), .enable(enable), .valid_in(valid_in), .byte_in(byte_in),
      .clear_cnt(clear_cnt), .locked(locked_a), .err_flag(err_flag_a),
      .bit_errs(bit_errs_a), .err_cnt(err_cnt_a), .byte_cnt(byte_cnt_a)
   );

   prbs15_checker #(.LOCK_CNT(4), .LOSS_CNT(4), .CNT_W(4)) dut_b (
      .clk(clk), .rst(rst), .enable(enable), .valid_in(valid_in), .byte_in(byte_in),
      .clear_cnt(clear_cnt), .locked(locked_b), .err_flag(err_flag_b),
      .bit_errs(bit_errs_b), .err_cnt(err_cnt_b), .byte_cnt(byte_cnt_b)
   );

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // reference generator: b[k] = b[k-14] ^ b[k-15], gen_q[14] newest bit
   task automatic gen_next(output logic [7:0] b);
      logic nb;
      b = '0;
      for (int i = 0; i < 8; i++) begin
         nb    = gen_q[1] ^ gen_q[0];
         b[i]  = nb;
         gen_q = {nb, gen_q[14:1]};
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [7:0] flip);
      logic [7:0] b;
      gen_next(b);
      byte_in  = b ^ flip;
      valid_in = 1'b1;
      tick();
      valid_in = 1'b0;
   endtask

   initial begin
      rst = 1'b1; enable = 1'b0; valid_in = 1'b0; clear_cnt = 1'b0; byte_in = '0;
      #2 rst = 1'b0;
      #2;
      check_eq("rst_locked",   32'(locked_a),   32'd0);
      check_eq("rst_err_flag", 32'(err_flag_a), 32'd0);
      check_eq("rst_bit_errs", 32'(bit_errs_a), 32'd0);
      check_eq("rst_err_cnt",  32'(err_cnt_a),  32'd0);
      check_eq("rst_byte_cnt", 32'(byte_cnt_a), 32'd0);
      check_eq("rst_err_cnt4", 32'(err_cnt_b),  32'd0);
      @(negedge clk);
      rst = 1'b1;

      // clean stream from seed 7FFF: lock after 2 seed + 4 verify bytes
      gen_q  = 15'h7FFF;
      enable = 1'b1;
      tick();
      for (int i = 0; i < 5; i++) begin
         send(8'h00);
         check_eq("pre_lock", 32'(locked_a), 32'd0);
      end
      send(8'h00);
      check_eq("lock_6th",      32'(locked_a),   32'd1);
      check_eq("lock_err_cnt",  32'(err_cnt_a),  32'd0);
      check_eq("lock_byte_cnt", 32'(byte_cnt_a), 32'd0);
      check_eq("lock_b",        32'(locked_b),   32'd1);

      // single bit error on the 10th byte
      for (int i = 0; i < 3; i++) send(8'h00);
      check_eq("byte_cnt_9", 32'(byte_cnt_a), 32'd3);
      send(8'h01);
      check_eq("e1_flag",     32'(err_flag_a), 32'd1);
      check_eq("e1_bit_errs", 32'(bit_errs_a), 32'd1);
      check_eq("e1_err_cnt",  32'(err_cnt_a),  32'd1);
      check_eq("e1_locked",   32'(locked_a),   32'd1);
      check_eq("e1_byte_cnt", 32'(byte_cnt_a), 32'd4);
      send(8'h00);
      check_eq("e1_flag_off", 32'(err_flag_a), 32'd0);
      check_eq("e1_bits_off", 32'(bit_errs_a), 32'd0);
      check_eq("e1_cnt_hold", 32'(err_cnt_a),  32'd1);

      // four inverted bytes drop lock
      for (int i = 0; i < 4; i++) begin
         send(8'hFF);
         check_eq("inv_bit_errs", 32'(bit_errs_a), 32'd8);
         check_eq("inv_flag",     32'(err_flag_a), 32'd1);
         check_eq("inv_locked",   32'(locked_a),   (i < 3) ? 32'd1 : 32'd0);
      end
      check_eq("inv_err_cnt",   32'(err_cnt_a),  32'd33);
      check_eq("inv_byte_cnt",  32'(byte_cnt_a), 32'd9);
      check_eq("sat_err_cnt4",  32'(err_cnt_b),  32'hF);
      check_eq("inv_byte_cnt4", 32'(byte_cnt_b), 32'd9);
      for (int i = 0; i < 5; i++) send(8'h00);
      check_eq("relock_pre", 32'(locked_a), 32'd0);
      send(8'h00);
      check_eq("relock",          32'(locked_a),   32'd1);
      check_eq("relock_byte_cnt", 32'(byte_cnt_a), 32'd9);

      // saturated counter holds on further errors
      send(8'h10);
      check_eq("post_err_cnt",   32'(err_cnt_a),  32'd34);
      check_eq("post_sat_cnt4",  32'(err_cnt_b),  32'hF);
      check_eq("post_byte_cnt",  32'(byte_cnt_a), 32'd10);

      // clear_cnt coincident with an errored locked byte
      clear_cnt = 1'b1;
      send(8'h03);
      clear_cnt = 1'b0;
      check_eq("clr_err_cnt",   32'(err_cnt_a),  32'd0);
      check_eq("clr_byte_cnt",  32'(byte_cnt_a), 32'd0);
      check_eq("clr_err_cnt4",  32'(err_cnt_b),  32'd0);
      check_eq("clr_flag",      32'(err_flag_a), 32'd1);
      check_eq("clr_bit_errs",  32'(bit_errs_a), 32'd2);
      send(8'h00);
      check_eq("clr_next_byte", 32'(byte_cnt_a), 32'd1);
      check_eq("clr_next_lock", 32'(locked_a),   32'd1);

      // disable, then reseed with valid_in toggling every cycle
      enable = 1'b0;
      tick();
      check_eq("dis_locked", 32'(locked_a), 32'd0);
      enable = 1'b1;
      gen_q  = 15'h7FFF;
      tick();
      for (int i = 0; i < 6; i++) begin
         send(8'h00);
         check_eq("tgl_lock", 32'(locked_a), (i == 5) ? 32'd1 : 32'd0);
         byte_in = 8'hA5;
         tick();
         check_eq("tgl_idle_lock", 32'(locked_a),   (i == 5) ? 32'd1 : 32'd0);
         check_eq("tgl_idle_flag", 32'(err_flag_a), 32'd0);
      end
      check_eq("tgl_byte_cnt", 32'(byte_cnt_a), 32'd1);

      // asynchronous reset while locked
      send(8'h80);
      check_eq("pre_rst_flag",  32'(err_flag_a), 32'd1);
      check_eq("pre_rst_cnt",   32'(err_cnt_a),  32'd1);
      check_eq("pre_rst_bytes", 32'(byte_cnt_a), 32'd2);
      #2 rst = 1'b0;
      #1;
      check_eq("arst_locked",   32'(locked_a),   32'd0);
      check_eq("arst_err_flag", 32'(err_flag_a), 32'd0);
      check_eq("arst_bit_errs", 32'(bit_errs_a), 32'd0);
      check_eq("arst_err_cnt",  32'(err_cnt_a),  32'd0);
      check_eq("arst_byte_cnt", 32'(byte_cnt_a), 32'd0);
      #2 rst = 1'b1;
      gen_q = 15'h7FFF;
      tick();
      for (int i = 0; i < 5; i++) send(8'h00);
      check_eq("rl_pre",     32'(locked_a),  32'd0);
      send(8'h00);
      check_eq("rl_locked",  32'(locked_a),  32'd1);
      check_eq("rl_err_cnt", 32'(err_cnt_a), 32'd0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
